// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, default vectors and alignment helper for pc_unit.
package pc_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0080;
    function automatic int align_bits(input int step);
        return $clog2(step);
    endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW-1:0] tp;
    logic [PW:0] occ;
    assign tp = sp - PW'(1);
    assign top = mem[tp];
    assign empty = occ == '0;
    assign full = occ == (PW+1)'(DEPTH);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
            occ <= '0;
        end else if (push) begin
            sp <= sp + PW'(1);
            occ <= full ? occ : occ + (PW+1)'(1);
        end else if (pop) begin
            sp <= tp;
            occ <= occ - (PW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[sp] <= din;
        else if (replace)
            mem[tp] <= din;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with BOOT/RUN/HALT control, prioritised redirects and alignment check.
// Define PC_RAS_EN to add the pc_ras return-address stack for call/ret.
module pc_unit
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DEF_EXC_VEC),
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             valid,
    output logic             misalign,
    output logic             ras_err
);
    localparam int AB = align_bits(STEP);
    localparam logic [WIDTH-1:0] LOW = WIDTH'((1 << AB) - 1);
    state_t state, state_n;
    logic [WIDTH-1:0] count_n, ras_top;
    logic valid_n, mis_n, err_n, rq, ras_empty, go, unused_ras;
    assign count_next = count + WIDTH'(STEP);
    assign go = state == RUN & ~exc & ~halt;
`ifdef PC_RAS_EN
    logic ras_full, ras_push, ras_pop, ras_rep, jc;
    assign rq = ret;
    assign jc = jmp & call;
    assign ras_push = go & jc & (~ret | ras_empty);
    assign ras_pop = go & ret & ~ras_empty & ~jc;
    assign ras_rep = go & ret & ~ras_empty & jc;
    assign unused_ras = ras_full;
    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .reset(reset),
        .push(ras_push),
        .pop(ras_pop),
        .replace(ras_rep),
        .din(count_next),
        .top(ras_top),
        .empty(ras_empty),
        .full(ras_full)
    );
`else
    assign rq = 1'b0;
    assign ras_top = '0;
    assign ras_empty = 1'b1;
    assign unused_ras = ^{call, ret, RAS_DEPTH[0]};
`endif
    always_comb begin
        state_n = state;
        valid_n = valid;
        count_n = count;
        mis_n = 1'b0;
        err_n = 1'b0;
        if (state == BOOT) begin
            state_n = RUN;
            valid_n = 1'b1;
        end else if (exc) begin
            state_n = RUN;
            valid_n = 1'b1;
            count_n = EXC_VEC;
        end else if (state == HALT) begin
            state_n = resume & ~halt ? RUN : HALT;
            valid_n = resume & ~halt;
            count_n = resume & ~halt ? count_next : count;
        end else if (halt) begin
            state_n = HALT;
            valid_n = 1'b0;
        end else begin
            count_n = rq ? (ras_empty ? count_next : ras_top) :
                      jmp ? jmp_target & ~LOW :
                      br_taken ? br_target & ~LOW :
                      stall ? count : count_next;
            mis_n = ~rq & (jmp ? |(jmp_target & LOW) : br_taken & |(br_target & LOW));
            err_n = rq & ras_empty;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            count <= RESET_VEC;
            valid <= 1'b0;
            misalign <= 1'b0;
            ras_err <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            valid <= valid_n;
            misalign <= mis_n;
            ras_err <= err_n;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a queue-based reference model.
module tb_pc_unit;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    logic clk = 0, reset = 0;
    logic stall, halt, resume, br_taken, jmp, call, ret, exc;
    logic [31:0] br_target, jmp_target, count, count_next;
    logic valid, misalign, ras_err;
    logic jmp8;
    logic [7:0] jt8, count8, cn8;
    logic valid8, mis8, err8;
    int total = 0, bad = 0;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
        .call(call), .ret(ret), .exc(exc), .count(count), .count_next(count_next),
        .valid(valid), .misalign(misalign), .ras_err(ras_err)
    );

    pc_unit #(.WIDTH(8), .RESET_VEC(8'hF0), .EXC_VEC(8'h80)) dut8 (
        .clk(clk), .reset(reset), .stall(1'b0), .halt(1'b0), .resume(1'b0),
        .br_taken(1'b0), .br_target(8'h00), .jmp(jmp8), .jmp_target(jt8),
        .call(1'b0), .ret(1'b0), .exc(1'b0), .count(count8), .count_next(cn8),
        .valid(valid8), .misalign(mis8), .ras_err(err8)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=boot 1=run 2=halted; stack newest at back.
    int m_mode;
    logic [31:0] m_count;
    bit m_valid, m_mis, m_err;
    logic [31:0] m_stack[$];

    function automatic void model_reset();
        m_mode = 0; m_count = 0; m_valid = 0; m_mis = 0; m_err = 0;
        m_stack.delete();
    endfunction

    function automatic void model_push(input logic [31:0] a);
        if (m_stack.size() == 4) void'(m_stack.pop_front());
        m_stack.push_back(a);
    endfunction

    function automatic void model_step();
        logic [31:0] seq, t;
        seq = m_count + 32'd4;
        m_mis = 0; m_err = 0;
        if (m_mode == 0) begin
            m_mode = 1; m_valid = 1;
        end else if (exc) begin
            m_mode = 1; m_valid = 1; m_count = 32'h80;
        end else if (m_mode == 2) begin
            if (resume && !halt) begin m_mode = 1; m_valid = 1; m_count = seq; end
        end else if (halt) begin
            m_mode = 2; m_valid = 0;
        end else if (RAS && ret) begin
            if (m_stack.size() == 0) begin
                m_err = 1;
                if (jmp && call) model_push(seq);
                m_count = seq;
            end else begin
                t = m_stack.pop_back();
                if (jmp && call) m_stack.push_back(seq);
                m_count = t;
            end
        end else if (jmp) begin
            if (RAS && call) model_push(seq);
            m_mis = (jmp_target % 4) != 0;
            m_count = (jmp_target / 4) * 4;
        end else if (br_taken) begin
            m_mis = (br_target % 4) != 0;
            m_count = (br_target / 4) * 4;
        end else if (!stall) begin
            m_count = seq;
        end
    endfunction

    task automatic clr();
        stall = 0; halt = 0; resume = 0; br_taken = 0; jmp = 0; call = 0; ret = 0; exc = 0;
        br_target = 0; jmp_target = 0; jmp8 = 0; jt8 = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_c[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        total++;
        if (count !== 32'h0 || valid !== 1'b0 || misalign !== 1'b0 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: count=%h valid=%b mis=%b err=%b want 0/0/0/0", count, valid, misalign, ras_err);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (count !== exp_c[i] || valid !== 1'b1) begin
                bad++;
                $display("FAIL boot_seq%0d: count=%h valid=%b want %h/1", i, count, valid, exp_c[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1;
        model_reset();
        #2;
        total++;
        if (count !== 32'h0 || valid !== 1'b0 || count8 !== 8'hF0) begin
            bad++;
            $display("FAIL reset_async: count=%h valid=%b count8=%h want 0/0/f0", count, valid, count8);
        end
        @(posedge clk);
        #1;
        reset = 0;
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        tick(); tick(); tick();
        br_taken = 1; br_target = 32'h40;
        tick();
        total++;
        if (count !== 32'h40 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL br_aligned: count=%h mis=%b want 40/0", count, misalign);
        end
        br_target = 32'h43;
        tick();
        total++;
        if (count !== 32'h40 || misalign !== 1'b1) begin
            bad++;
            $display("FAIL br_misaligned: count=%h mis=%b want 40/1", count, misalign);
        end
        clr();
        tick();
        total++;
        if (count !== 32'h44 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL mis_pulse: count=%h mis=%b want 44/0", count, misalign);
        end
    endtask

    task automatic test_exc();
        exc = 1; jmp = 1; jmp_target = 32'h200; stall = 1;
        tick();
        total++;
        if (count !== 32'h80 || valid !== 1'b1) begin
            bad++;
            $display("FAIL exc_priority: count=%h valid=%b want 80/1", count, valid);
        end
        clr();
        tick();
        halt = 1;
        tick();
        total++;
        if (count !== 32'h84 || valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_enter: count=%h valid=%b want 84/0", count, valid);
        end
        halt = 0; exc = 1;
        tick();
        total++;
        if (count !== 32'h80 || valid !== 1'b1) begin
            bad++;
            $display("FAIL exc_in_halt: count=%h valid=%b want 80/1", count, valid);
        end
        clr();
    endtask

    task automatic test_halt();
        jmp = 1; jmp_target = 32'h10;
        tick();
        clr();
        halt = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            halt = 0;
            resume = i == 2;
            halt = i == 2;
            total++;
            if (count !== 32'h10 || valid !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold%0d: count=%h valid=%b want 10/0", i, count, valid);
            end
        end
        halt = 0; resume = 1;
        tick();
        total++;
        if (count !== 32'h14 || valid !== 1'b1) begin
            bad++;
            $display("FAIL resume: count=%h valid=%b want 14/1", count, valid);
        end
        clr();
    endtask

    task automatic test_wrap();
        jmp8 = 1; jt8 = 8'hFC;
        tick();
        jmp8 = 0;
        total++;
        if (count8 !== 8'hFC || cn8 !== 8'h00) begin
            bad++;
            $display("FAIL wrap_pre: count8=%h next=%h want fc/00", count8, cn8);
        end
        tick();
        total++;
        if (count8 !== 8'h00 || mis8 !== 1'b0 || err8 !== 1'b0 || valid8 !== 1'b1) begin
            bad++;
            $display("FAIL wrap: count8=%h mis=%b err=%b valid=%b want 00/0/0/1", count8, mis8, err8, valid8);
        end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [31:0] rets[5];
        logic [31:0] cur;
        do_reset();
        tick();
        cur = 32'h0;
        for (int i = 0; i < 5; i++) begin
            jmp = 1; call = 1; jmp_target = 32'h100 * (i + 1);
            rets[i] = cur + 32'd4;
            cur = jmp_target;
            tick();
        end
        clr();
        ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (count !== rets[4-i] || ras_err !== 1'b0) begin
                bad++;
                $display("FAIL ras_pop%0d: count=%h err=%b want %h/0", i, count, ras_err, rets[4-i]);
            end
            cur = rets[4-i];
        end
        tick();
        total++;
        if (count !== cur + 32'd4 || ras_err !== 1'b1) begin
            bad++;
            $display("FAIL ras_underflow: count=%h err=%b want %h/1", count, ras_err, cur + 32'd4);
        end
        clr();
        tick();
        total++;
        if (ras_err !== 1'b0) begin
            bad++;
            $display("FAIL ras_err_pulse: err=%b want 0", ras_err);
        end
    endtask
`else
    task automatic test_ras();
        jmp = 1; jmp_target = 32'h300;
        tick();
        clr();
        ret = 1;
        tick();
        total++;
        if (count !== 32'h304 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL ret_ignored: count=%h err=%b want 304/0", count, ras_err);
        end
        jmp = 1; call = 1; jmp_target = 32'h500;
        tick();
        total++;
        if (count !== 32'h500 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL call_ignored: count=%h err=%b want 500/0", count, ras_err);
        end
        clr();
    endtask
`endif

    task automatic test_random();
        do_reset();
        tick();
        for (int i = 0; i < 400; i++) begin
            exc = $urandom_range(15) == 0;
            halt = $urandom_range(9) == 0;
            resume = $urandom_range(2) == 0;
            stall = $urandom_range(4) == 0;
            ret = $urandom_range(5) == 0;
            jmp = $urandom_range(5) == 0;
            call = $urandom_range(1) == 0;
            br_taken = $urandom_range(5) == 0;
            jmp_target = $urandom;
            br_target = $urandom;
            tick();
            total++;
            if (count !== m_count || valid !== m_valid || misalign !== m_mis ||
                ras_err !== m_err || count_next !== m_count + 32'd4) begin
                bad++;
                $display("FAIL random%0d: count=%h valid=%b mis=%b err=%b next=%h want %h/%b/%b/%b/%h",
                         i, count, valid, misalign, ras_err, count_next,
                         m_count, m_valid, m_mis, m_err, m_count + 32'd4);
            end
        end
        clr();
    endtask

    initial begin
        clr();
        test_reset();
        test_reset_mid();
        test_branch();
        test_exc();
        test_halt();
        test_wrap();
        test_ras();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
